rpn_entry_sequencer: RTL

- Transaction-level driver for the RPN calculator's Enter/DataIn entry interface.
- Accepts one operation (operand A, operand B, opcode) via a start/busy/done handshake.
- Produces the timed Enter/DataIn pulse sequence the calculator expects, waits for the result, captures ToDisplay/Flags, then issues the acknowledge Enter pulse.
- Sits between a host (test harness, switch front-end or script ROM) and the calculator.

---
 rtl/rpn_pkg.sv | 36 +++
 rtl/rpn_entry_sequencer_if.sv | 28 ++
 rtl/rpn_phase_timer.sv | 35 +++
 rtl/rpn_entry_sequencer.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/rpn_pkg.sv
// rtl/rpn_pkg.sv - shared types, constants and sizing helpers for the RPN entry sequencer
package rpn_pkg;

    localparam int RPN_DATA_W = 16;
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        HOLD,
        SETTLE,
        CAPTURE,
        ACK_HOLD,
        ACK_GAP,
        DONE
    } seq_state_t;

    typedef enum logic [1:0] {
        PH_A,
        PH_B,
        PH_OP
    } phase_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // A one-cycle maximum still needs a one-bit counter to hold the zero value.
    function automatic int cnt_width(input int max_dur);
        return (max_dur > 1) ? $clog2(max_dur) : 1;
    endfunction

endpackage

// File: rtl/rpn_entry_sequencer_if.sv
// rtl/rpn_entry_sequencer_if.sv - host and calculator signals of the entry sequencer
interface rpn_entry_sequencer_if #(
    parameter int DATA_W = 16
);
    logic              start;
    logic              abort;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [1:0]        op_code;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic [3:0]        result_flags;
    logic              Enter;
    logic [DATA_W-1:0] DataIn;
    logic [3:0]        Flags;
    logic [DATA_W-1:0] ToDisplay;

    modport master (
        output start, abort, op_a, op_b, op_code, Flags, ToDisplay,
        input  busy, done, result, result_flags, Enter, DataIn
    );

    modport slave (
        input  start, abort, op_a, op_b, op_code, Flags, ToDisplay,
        output busy, done, result, result_flags, Enter, DataIn
    );
endinterface

// File: rtl/rpn_phase_timer.sv
// rtl/rpn_phase_timer.sv - loadable down-counter that flags when the current state has expired
module rpn_phase_timer
    import rpn_pkg::*;
#(
    parameter int MAX_DUR = 40,
    parameter int CNT_W   = cnt_width(MAX_DUR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    output logic             zero
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);
endmodule

// File: rtl/rpn_entry_sequencer.sv
// rtl/rpn_entry_sequencer.sv - drives one A/B/opcode entry plus acknowledge into the RPN calculator
module rpn_entry_sequencer
    import rpn_pkg::*;
#(
    parameter int DATA_W        = RPN_DATA_W,
    parameter int GAP_CYCLES    = 2,
    parameter int HOLD_CYCLES   = 20,
    parameter int SETTLE_CYCLES = 40
) (
    input  logic                  clk,
    input  logic                  reset,
    rpn_entry_sequencer_if.slave  bus
);
    localparam int MAX_DUR = max3(GAP_CYCLES, HOLD_CYCLES, SETTLE_CYCLES);
    localparam int CNT_W   = cnt_width(MAX_DUR);
    localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);

    seq_state_t        state_q, state_d;
    phase_t            phase_q, phase_d;
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [1:0]        op_code_q, op_code_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [3:0]        result_flags_q, result_flags_d;
    logic              enter_q, enter_d, busy_q, busy_d, done_q, done_d;
    logic              tmr_load, tmr_zero;
    logic [CNT_W-1:0]  tmr_value;

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        op_code_d      = op_code_q;
        data_in_d      = data_in_q;
        result_d       = result_q;
        result_flags_d = result_flags_q;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    op_a_d    = bus.op_a;
                    op_b_d    = bus.op_b;
                    op_code_d = bus.op_code;
                    phase_d   = PH_A;
                    state_d   = GAP;
                end
            end
            GAP:      if (tmr_zero) state_d = HOLD;
            HOLD: begin
                if (tmr_zero) begin
                    if (phase_q == PH_OP) begin
                        state_d = SETTLE;
                    end else begin
                        phase_d = (phase_q == PH_A) ? PH_B : PH_OP;
                        state_d = GAP;
                    end
                end
            end
            SETTLE:   if (tmr_zero) state_d = CAPTURE;
            CAPTURE: begin
                result_d       = bus.ToDisplay;
                result_flags_d = bus.Flags;
                state_d        = ACK_HOLD;
            end
            ACK_HOLD: if (tmr_zero) state_d = ACK_GAP;
            ACK_GAP:  if (tmr_zero) state_d = DONE;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        // Abort drops straight to IDLE; captured result and the bus value are left as they were.
        if (state_q != IDLE && bus.abort) begin
            state_d        = IDLE;
            phase_d        = phase_q;
            result_d       = result_q;
            result_flags_d = result_flags_q;
        end

        if (state_d == GAP && state_q != GAP) begin
            case (phase_d)
                PH_A:    data_in_d = op_a_d;
                PH_B:    data_in_d = op_b_d;
                default: data_in_d = {{(DATA_W-2){1'b0}}, op_code_d};
            endcase
        end

        enter_d = (state_d == HOLD) || (state_d == ACK_HOLD);
        busy_d  = (state_d != IDLE);
        done_d  = (state_d == DONE);

        tmr_load = (state_d != state_q);
        case (state_d)
            GAP, ACK_GAP:   tmr_value = GAP_LD;
            HOLD, ACK_HOLD: tmr_value = HOLD_LD;
            SETTLE:         tmr_value = SETTLE_LD;
            default:        tmr_value = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            phase_q        <= PH_A;
            op_a_q         <= '0;
            op_b_q         <= '0;
            op_code_q      <= '0;
            data_in_q      <= '0;
            result_q       <= '0;
            result_flags_q <= '0;
            enter_q        <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            phase_q        <= phase_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            op_code_q      <= op_code_d;
            data_in_q      <= data_in_d;
            result_q       <= result_d;
            result_flags_q <= result_flags_d;
            enter_q        <= enter_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
        end
    end

    rpn_phase_timer #(
        .MAX_DUR (MAX_DUR),
        .CNT_W   (CNT_W)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (tmr_load),
        .value (tmr_value),
        .zero  (tmr_zero)
    );

    assign bus.Enter        = enter_q;
    assign bus.DataIn       = data_in_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.result       = result_q;
    assign bus.result_flags = result_flags_q;
endmodule
